aes_dec_arbiter: RTL
====================

AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin between clients, 0 = fixed priority to client 0.
REQ-002 The block SHALL provide port clk, input, 1 bit, system clock, rising-edge active.
REQ-003 The block SHALL provide port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL provide ports c0_req / c1_req, input, 1 bit each, client requests one block decipher.
REQ-005 The block SHALL provide ports c0_keylen / c1_keylen, input, 1 bit each, 0 = AES-128, 1 = AES-256.
REQ-006 The block SHALL provide ports c0_block / c1_block, input, 128 bits each, ciphertext.
REQ-007 The block SHALL provide ports c0_ack / c1_ack, output, 1 bit each, one-cycle pulse when the request is accepted.
REQ-008 The block SHALL provide ports c0_valid / c1_valid, output, 1 bit each, result available.
REQ-009 The block SHALL provide ports c0_taken / c1_taken, input, 1 bit each, client consumes the result.
REQ-010 The block SHALL provide port result, output, 128 bits, plaintext for the client whose valid is high.
REQ-011 The block SHALL provide ports c0_rkey_idx / c1_rkey_idx, output, 4 bits each, round index to the client key store.
REQ-012 The block SHALL provide ports c0_rkey / c1_rkey, input, 128 bits each, round key returned combinationally by the client key store.
REQ-013 The block SHALL provide port eng_next, output, 1 bit, start pulse to the decipher round engine.
REQ-014 The block SHALL provide port eng_keylen, output, 1 bit, latched keylen.
REQ-015 The block SHALL provide port eng_block, output, 128 bits, latched ciphertext.
REQ-016 The block SHALL provide port eng_round_key, output, 128 bits, muxed round key.
REQ-017 The block SHALL provide port eng_round, input, 4 bits, engine round counter.
REQ-018 The block SHALL provide port eng_new_block, input, 128 bits, engine output.
REQ-019 The block SHALL provide port eng_ready, input, 1 bit, engine idle/done.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-021 IDLE: if eng_ready=1 and any req=1, the block SHALL:
- choose a grant;
- latch grant, keylen and block of the winner;
- go to START.
Otherwise it SHALL stay in IDLE.
REQ-022 Arbitration when only one req=1 SHALL grant that client.
REQ-023 Arbitration when both req=1 SHALL grant, with FAIR=1, the client other than last_grant; with FAIR=0, client 0.
REQ-024 START (exactly one cycle): the block SHALL assert eng_next=1 and ack of the granted client =1, then go to WAIT.
REQ-025 WAIT: the first WAIT cycle SHALL ignore eng_ready. On a later cycle with eng_ready=1, the block SHALL register eng_new_block into result and go to DONE.
REQ-026 DONE: valid of the granted client SHALL be 1 and result SHALL be held stable. On taken of the granted client =1, the block SHALL update last_grant and go to IDLE.
REQ-027 Taken from the non-granted client, and taken outside DONE, SHALL be ignored.
REQ-028 A request arriving in the same cycle as taken SHALL be arbitrated no earlier than the following (IDLE) cycle.
REQ-029 A client SHALL hold req and block until its ack. Req sampled only in IDLE. Dropping req before grant cancels it without side effects.
REQ-030 eng_round_key SHALL equal c0_rkey when grant=0 and c1_rkey when grant=1, combinationally.
REQ-031 The granted client's rkey_idx SHALL equal eng_round. The non-granted client's rkey_idx SHALL be 0.
REQ-032 eng_keylen and eng_block SHALL hold the latched values from START until the next grant.
REQ-033 The block SHALL compute no cipher data itself; result SHALL be bit-exact eng_new_block.
REQ-034 Latency: result valid SHALL assert exactly 1 cycle after eng_ready rises in WAIT. Accept-to-valid SHALL be 3 cycles plus the engine busy time.

Reset
REQ-035 On reset_n=0 the block SHALL asynchronously set:
- state=IDLE, grant=0, last_grant=1;
- result=0, eng_block=0, eng_keylen=0;
- all ack, valid and eng_next outputs =0;
- all rkey_idx=0.
REQ-036 A reset mid-operation SHALL abandon the operation silently: no valid, no ack; the engine shares reset_n.
REQ-037 In the first cycle after reset release, IDLE SHALL arbitrate normally.

Verification
REQ-038 Scenario: c0 only, keylen=0, FIPS-197 C.1 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with matching key store -> c0_ack one pulse; c0_valid with result 00112233445566778899aabbccddeeff; c1 outputs stay 0.
REQ-039 Scenario: c1 only, keylen=1, C.3 ciphertext 8ea2b7ca516745bfeafc49904b496089 -> c1_valid with 00112233445566778899aabbccddeeff; eng_keylen=1 throughout.
REQ-040 Scenario: FAIR=1, both req held for 4 operations -> grant order 0,1,0,1; FAIR=0 -> 0,0,0,0.
REQ-041 Scenario: delay c0_taken 20 cycles in DONE -> result stable, no eng_next, c1 request waits; c1_ack arrives 2 cycles after the taken cycle.
REQ-042 Scenario: assert reset_n=0 in WAIT at round 5 -> all outputs 0 immediately; after release, a fresh c1 request completes correctly.
REQ-043 Scenario: check c0_rkey_idx against eng_round every WAIT cycle while c0 is granted; c1_rkey_idx =0 throughout.

Source files
------------

// File: rtl/aes_dec_arbiter.sv
// Two-client front end for a shared AES decipher round engine: arbitrates requests,
// routes each client's key store to the engine and returns the plaintext to the winner.
module aes_dec_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         c0_req,
    input  logic         c1_req,
    input  logic         c0_keylen,
    input  logic         c1_keylen,
    input  logic [127:0] c0_block,
    input  logic [127:0] c1_block,
    output logic         c0_ack,
    output logic         c1_ack,
    output logic         c0_valid,
    output logic         c1_valid,
    input  logic         c0_taken,
    input  logic         c1_taken,
    output logic [127:0] result,
    output logic [3:0]   c0_rkey_idx,
    output logic [3:0]   c1_rkey_idx,
    input  logic [127:0] c0_rkey,
    input  logic [127:0] c1_rkey,
    output logic         eng_next,
    output logic         eng_keylen,
    output logic [127:0] eng_block,
    output logic [127:0] eng_round_key,
    input  logic [3:0]   eng_round,
    input  logic [127:0] eng_new_block,
    input  logic         eng_ready
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e state;
    logic   grant;
    logic   last_grant;
    logic   first_wait;
    logic   win;
    logic   busy;

    // Contention goes to the client that did not finish last, unless fixed priority.
    always_comb begin
        if (c0_req && c1_req) begin
            win = (FAIR != 0) ? ~last_grant : 1'b0;
        end else begin
            win = c1_req;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            first_wait <= 1'b0;
            result     <= '0;
            eng_block  <= '0;
            eng_keylen <= 1'b0;
            eng_next   <= 1'b0;
            c0_ack     <= 1'b0;
            c1_ack     <= 1'b0;
            c0_valid   <= 1'b0;
            c1_valid   <= 1'b0;
        end else begin
            c0_ack   <= 1'b0;
            c1_ack   <= 1'b0;
            eng_next <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (eng_ready && (c0_req || c1_req)) begin
                        grant      <= win;
                        eng_keylen <= win ? c1_keylen : c0_keylen;
                        eng_block  <= win ? c1_block : c0_block;
                        c0_ack     <= ~win;
                        c1_ack     <= win;
                        eng_next   <= 1'b1;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    first_wait <= 1'b1;
                    state      <= StWait;
                end
                StWait: begin
                    // eng_ready may still show the previous completion on the first cycle
                    first_wait <= 1'b0;
                    if (!first_wait && eng_ready) begin
                        result   <= eng_new_block;
                        c0_valid <= ~grant;
                        c1_valid <= grant;
                        state    <= StDone;
                    end
                end
                StDone: begin
                    if (grant ? c1_taken : c0_taken) begin
                        last_grant <= grant;
                        c0_valid   <= 1'b0;
                        c1_valid   <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy          = (state != StIdle);
    assign c0_rkey_idx   = (busy && !grant) ? eng_round : 4'd0;
    assign c1_rkey_idx   = (busy && grant) ? eng_round : 4'd0;
    assign eng_round_key = grant ? c1_rkey : c0_rkey;

endmodule
